// File: rtl/input_port_request_ctrl.sv
// -----------------------------------------------------------------------------
// input_port_request_ctrl
//
// Per-input-port request controller of a 2D-mesh router. It watches the head
// of the input FIFO (first-word-fall-through), computes the XY route of each
// packet's head flit and holds a one-hot request toward that output port until
// the whole packet has crossed. It then drops the request for one cycle so the
// output allocator sees the release before any new request. Flits are paced
// by grant plus downstream credit.
//
// Flit type in bits [FLIT_W-1:FLIT_W-2]: 01 head, 00 body, 10 tail,
// 11 single (head+tail). A head flit carries dest X in [3:2], dest Y in [1:0].
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   fifo_empty        input FIFO is empty
//   fifo_data         FIFO head flit (FWFT)
//   fifo_rd           pop the FIFO this cycle
//   req_*             one-hot request to the output allocators
//   grant_*           output port granted to this input
//   credit_avail      downstream space per output {south,east,north,west,local}
//   flit_valid        fifo_data is driven into the crossbar this cycle
//   sel_port          crossbar select 0 local,1 west,2 north,3 east,4 south; 7 idle
//   pkt_err           (IPRC_PKT_ERR_DROP_EN only) sticky stray-flit error flag
//
// Build option
//   IPRC_PKT_ERR_DROP_EN  when defined, a body/tail flit found at the FIFO head
//                         while idle is popped and discarded and pkt_err is set.
//                         When undefined, every flit seen while idle is routed
//                         as a head flit.
// -----------------------------------------------------------------------------
module input_port_request_ctrl #(
  parameter int FLIT_W = 16,
  parameter int CUR_X  = 0,
  parameter int CUR_Y  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [FLIT_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              req_local,
  output logic              req_west,
  output logic              req_north,
  output logic              req_east,
  output logic              req_south,
  input  logic              grant_local,
  input  logic              grant_west,
  input  logic              grant_north,
  input  logic              grant_east,
  input  logic              grant_south,
  input  logic [4:0]        credit_avail,
`ifdef IPRC_PKT_ERR_DROP_EN
  output logic              pkt_err,
`endif
  output logic              flit_valid,
  output logic [2:0]        sel_port
);

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_WEST  = 3'd1;
  localparam logic [2:0] PORT_NORTH = 3'd2;
  localparam logic [2:0] PORT_EAST  = 3'd3;
  localparam logic [2:0] PORT_SOUTH = 3'd4;
  localparam logic [2:0] PORT_NONE  = 3'd7;

  localparam logic [1:0] CX = CUR_X[1:0];
  localparam logic [1:0] CY = CUR_Y[1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACTIVE,
    S_RELEASE
  } state_e;

  state_e     state_q;
  logic [2:0] port_q;
  logic [4:0] req_q;    // {south, east, north, west, local}

  logic [2:0] route_d;
  logic       is_head;
  logic       is_tail;
  logic       head_ok;
  logic       drop;
  logic       xfer;
  logic [7:0] grant_pad;
  logic [7:0] credit_pad;

  assign is_head = fifo_data[FLIT_W-2];   // head (01) or single (11)
  assign is_tail = fifo_data[FLIT_W-1];   // tail (10) or single (11)

  // Port register only ever holds 0..4; padding to 8 keeps the index in range.
  assign grant_pad  = {3'b000, grant_south, grant_east, grant_north, grant_west, grant_local};
  assign credit_pad = {3'b000, credit_avail};

  // XY routing of the flit currently at the FIFO head: resolve X first, then Y.
  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    route_d = PORT_LOCAL;
    if (fifo_data[3:2] > CX)      route_d = PORT_EAST;
    else if (fifo_data[3:2] < CX) route_d = PORT_WEST;
    else if (fifo_data[1:0] > CY) route_d = PORT_SOUTH;
    else if (fifo_data[1:0] < CY) route_d = PORT_NORTH;
  end

  // A flit moves only when the held port is granted, has downstream space and
  // there is something to send.
  assign xfer = (state_q == S_ACTIVE) & grant_pad[port_q] & credit_pad[port_q] & ~fifo_empty;

`ifdef IPRC_PKT_ERR_DROP_EN
  // Only genuine head flits open a packet; strays are discarded while idle.
  assign head_ok = is_head;
  assign drop    = (state_q == S_IDLE) & ~fifo_empty & ~is_head;

  logic pkt_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pkt_err_q <= 1'b0;
    else if (drop) pkt_err_q <= 1'b1;
  end

  assign pkt_err = pkt_err_q;

  logic unused_ok;
  assign unused_ok = ^fifo_data[FLIT_W-3:4];
`else
  // Whatever sits at the FIFO head while idle is treated as a head flit.
  assign head_ok = 1'b1;
  assign drop    = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{fifo_data[FLIT_W-3:4], is_head};
`endif

  assign fifo_rd    = xfer | drop;
  assign flit_valid = xfer;
  assign sel_port   = (state_q == S_ACTIVE) ? port_q : PORT_NONE;

  assign req_local = req_q[0];
  assign req_west  = req_q[1];
  assign req_north = req_q[2];
  assign req_east  = req_q[3];
  assign req_south = req_q[4];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      port_q  <= PORT_LOCAL;
      req_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // The head flit stays in the FIFO; it is popped as the first transfer.
          if (!fifo_empty && head_ok) begin
            port_q  <= route_d;
            req_q   <= 5'b00001 << route_d;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (grant_pad[port_q]) state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (xfer && is_tail) begin
            req_q   <= '0;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // One request-free cycle lets the allocator observe the release.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_request_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for input_port_request_ctrl (router at X=1, Y=1 so every direction is
// reachable). A packet-level model predicts the request, transfer and select
// outputs each cycle; directed sequences pin exact cycle timing with literals,
// then randomized packets, grants and credits exercise the rest.
// -----------------------------------------------------------------------------
module tb_input_port_request_ctrl;

  localparam int FLIT_W = 16;
  localparam int CUR_X  = 1;
  localparam int CUR_Y  = 1;
`ifdef IPRC_PKT_ERR_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fifo_empty;
  logic [FLIT_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              req_local, req_west, req_north, req_east, req_south;
  logic              grant_local, grant_west, grant_north, grant_east, grant_south;
  logic [4:0]        credit_avail;
  logic              flit_valid;
  logic [2:0]        sel_port;
`ifdef IPRC_PKT_ERR_DROP_EN
  logic              pkt_err;
`endif

  always #5 clk = ~clk;

  input_port_request_ctrl #(.FLIT_W(FLIT_W), .CUR_X(CUR_X), .CUR_Y(CUR_Y)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd      (fifo_rd),
    .req_local    (req_local),
    .req_west     (req_west),
    .req_north    (req_north),
    .req_east     (req_east),
    .req_south    (req_south),
    .grant_local  (grant_local),
    .grant_west   (grant_west),
    .grant_north  (grant_north),
    .grant_east   (grant_east),
    .grant_south  (grant_south),
    .credit_avail (credit_avail),
`ifdef IPRC_PKT_ERR_DROP_EN
    .pkt_err      (pkt_err),
`endif
    .flit_valid   (flit_valid),
    .sel_port     (sel_port)
  );

  // Input FIFO environment
  logic [FLIT_W-1:0] fifo_q[$];
  bit                pop_pending;

  // Packet-level model: is a packet owned, has it been granted, release gap
  bit m_pkt, m_granted, m_gap, m_err;
  int m_port;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sync_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  function automatic int route(input logic [FLIT_W-1:0] f);
    int dx = int'(f[3:2]);
    int dy = int'(f[1:0]);
    if (dx > CUR_X) return 3;
    if (dx < CUR_X) return 1;
    if (dy > CUR_Y) return 4;
    if (dy < CUR_Y) return 2;
    return 0;
  endfunction

  function automatic logic grant_of(input int p);
    case (p)
      0: return grant_local;
      1: return grant_west;
      2: return grant_north;
      3: return grant_east;
      default: return grant_south;
    endcase
  endfunction

  function automatic int req_vec();
    return int'({req_south, req_east, req_north, req_west, req_local});
  endfunction

  task automatic push_pkt(input logic [1:0] dx, input logic [1:0] dy, input int nbody, input bit single);
    logic [9:0]  pay;
    logic [13:0] body;
    pay = 10'($urandom);
    if (single) begin
      fifo_q.push_back({2'b11, pay, dx, dy});
    end else begin
      fifo_q.push_back({2'b01, pay, dx, dy});
      for (int i = 0; i < nbody; i++) begin
        body = 14'($urandom);
        fifo_q.push_back({2'b00, body});
      end
      body = 14'($urandom);
      fifo_q.push_back({2'b10, body});
    end
    sync_fifo();
  endtask

  task automatic set_grants(input logic [4:0] g);
    {grant_south, grant_east, grant_north, grant_west, grant_local} = g;
  endtask

  // Called at the falling edge: compare DUT to model, then step the model.
  task automatic check_cycle();
    int  exp_req, exp_sel;
    bit  exp_x, exp_drop;
    exp_req  = m_pkt ? (1 << m_port) : 0;
    exp_x    = m_pkt && m_granted && grant_of(m_port) && credit_avail[m_port] && !fifo_empty;
    exp_drop = DROP_EN && !m_pkt && !m_gap && !fifo_empty && !fifo_data[FLIT_W-2];
    exp_sel  = (m_pkt && m_granted) ? m_port : 7;

    check("req", req_vec(), exp_req);
    check("fifo_rd", int'(fifo_rd), int'(exp_x | exp_drop));
    check("flit_valid", int'(flit_valid), int'(exp_x));
    check("sel_port", int'(sel_port), exp_sel);
    check("req_onehot0", int'($onehot0(req_vec())), 1);
`ifdef IPRC_PKT_ERR_DROP_EN
    check("pkt_err", int'(pkt_err), int'(m_err));
`endif

    if (m_gap) begin
      m_gap = 1'b0;
    end else if (!m_pkt) begin
      if (!fifo_empty) begin
        if (DROP_EN && !fifo_data[FLIT_W-2]) begin
          m_err = 1'b1;
        end else begin
          m_pkt     = 1'b1;
          m_granted = 1'b0;
          m_port    = route(fifo_data);
        end
      end
    end else if (!m_granted) begin
      if (grant_of(m_port)) m_granted = 1'b1;
    end else if (exp_x && fifo_data[FLIT_W-1]) begin
      m_pkt = 1'b0;
      m_gap = 1'b1;
    end
    pop_pending = exp_x | exp_drop;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (pop_pending) void'(fifo_q.pop_front());
    pop_pending = 1'b0;
    sync_fifo();
  endtask

  // Literal expectations for the directed sequences
  int t1_req[7] = '{0, 1, 1, 1, 1, 0, 0};
  int t1_rd [7] = '{0, 0, 1, 1, 1, 0, 0};
  int t1_sel[7] = '{7, 7, 3, 3, 3, 7, 7};
  int t2_req[5] = '{0, 1, 1, 0, 0};
  int t2_rd [5] = '{0, 0, 1, 0, 0};
  int t2_sel[5] = '{7, 7, 0, 7, 7};
  int t3_req[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int t3_rd [9] = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
  int t4_req[11] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
  int t4_rd [11] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0};

  initial begin
    rst_n        = 1'b0;
    credit_avail = 5'h1f;
    set_grants(5'b0);
    pop_pending  = 1'b0;
    m_pkt = 0; m_granted = 0; m_gap = 0; m_err = 0; m_port = 0;
    sync_fifo();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", req_vec(), 0);
    check("rst_fifo_rd", int'(fifo_rd), 0);
    check("rst_flit_valid", int'(flit_valid), 0);
    check("rst_sel_port", int'(sel_port), 7);
    rst_n = 1'b1;
    advance();

    // 1: east, 3-flit packet; grant present from the REQ cycle on
    push_pkt(2'd3, 2'd1, 1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle();
      check($sformatf("t1_req_east[%0d]", i), int'(req_east), t1_req[i]);
      check($sformatf("t1_rd[%0d]", i), int'(fifo_rd), t1_rd[i]);
      check($sformatf("t1_sel[%0d]", i), int'(sel_port), t1_sel[i]);
      advance();
      if (i == 0) grant_east = 1'b1;
    end
    set_grants(5'b0);

    // 2: single flit to local
    grant_local = 1'b1;
    push_pkt(2'd1, 2'd1, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("t2_req_local[%0d]", i), int'(req_local), t2_req[i]);
      check($sformatf("t2_rd[%0d]", i), int'(fifo_rd), t2_rd[i]);
      check($sformatf("t2_sel[%0d]", i), int'(sel_port), t2_sel[i]);
      advance();
    end
    set_grants(5'b0);

    // 3: south, 4 flits, two credit-less cycles mid-packet
    grant_south = 1'b1;
    push_pkt(2'd1, 2'd3, 2, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cycle();
      check($sformatf("t3_req_south[%0d]", i), int'(req_south), t3_req[i]);
      check($sformatf("t3_rd[%0d]", i), int'(fifo_rd), t3_rd[i]);
      advance();
      if (i == 3) credit_avail[4] = 1'b0;
      if (i == 5) credit_avail[4] = 1'b1;
    end
    check("t3_fifo_drained", fifo_q.size(), 0);
    set_grants(5'b0);

    // 4: two back-to-back packets to north
    grant_north = 1'b1;
    push_pkt(2'd1, 2'd0, 0, 1'b0);
    push_pkt(2'd1, 2'd0, 0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      cycle();
      check($sformatf("t4_req_north[%0d]", i), int'(req_north), t4_req[i]);
      check($sformatf("t4_rd[%0d]", i), int'(fifo_rd), t4_rd[i]);
      advance();
    end
    set_grants(5'b0);

    // 5: asynchronous reset while transferring
    grant_east = 1'b1;
    push_pkt(2'd2, 2'd0, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i < 3) advance();
    end
    check("t5_pre_rd", int'(fifo_rd), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_req", req_vec(), 0);
    check("t5_rst_fifo_rd", int'(fifo_rd), 0);
    check("t5_rst_flit_valid", int'(flit_valid), 0);
    check("t5_rst_sel_port", int'(sel_port), 7);
    fifo_q.delete();
    pop_pending = 1'b0;
    m_pkt = 0; m_granted = 0; m_gap = 0; m_err = 0;
    sync_fifo();
    set_grants(5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    advance();

`ifdef IPRC_PKT_ERR_DROP_EN
    // 6: stray body flit in idle is popped and flagged
    fifo_q.push_back({2'b00, 14'h1234});
    sync_fifo();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("t6_rd[%0d]", i), int'(fifo_rd), (i == 0) ? 1 : 0);
      check($sformatf("t6_req[%0d]", i), req_vec(), 0);
      check($sformatf("t6_err[%0d]", i), int'(pkt_err), (i == 0) ? 0 : 1);
      advance();
    end
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cycle();
      advance();
      set_grants(5'($urandom));
      for (int p = 0; p < 5; p++) credit_avail[p] = ($urandom_range(0, 4) != 0);
      if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) begin
        int kind = $urandom_range(0, 9);
        if (kind < 2) begin
          push_pkt(2'($urandom), 2'($urandom), 0, 1'b1);
        end else if (kind == 2) begin
          fifo_q.push_back({($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, 14'($urandom)});
          sync_fifo();
        end else begin
          push_pkt(2'($urandom), 2'($urandom), $urandom_range(0, 3), 1'b0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
